apb_mux_tmo: RTL
================

// Module: apb_mux_tmo
// PURPOSE
//  APB4 slave multiplexer, successor to the combinational mux.
//  Sits between one APB master and SLAVES slaves. Decodes PSEL by address/mask with lowest-index priority.
//  Latches the selected slave for the whole transfer and steers PRDATA/PREADY/PSLVERR back to the master.
//  Answers unmapped addresses with an error and can abort hung slaves with a watchdog timeout.
// PARAMETERS
//  PADDR_SIZE  8    width of decoded address MSBs
//  PDATA_SIZE  32   read data width
//  SLAVES      8    number of slave ports (>=1)
//  TIMEOUT     255  max access-phase wait cycles before abort (>=1; used only with APB_MUX_TIMEOUT_EN)
// PORTS
//  PCLK         in   1                       clock, all state on rising edge
//  PRESET       in   1                       reset, synchronous, active-high
//  MST_PSEL     in   1                       master select
//  MST_PENABLE  in   1                       master enable (access phase)
//  MST_PADDR    in   PADDR_SIZE              address MSBs
//  MST_PRDATA   out  PDATA_SIZE              read data to master
//  MST_PREADY   out  1                       ready to master
//  MST_PSLVERR  out  1                       error to master
//  slv_addr     in   [SLAVES][PADDR_SIZE]    per-slave base compare value
//  slv_mask     in   [SLAVES][PADDR_SIZE]    per-slave compare mask (1 = bit compared)
//  SLV_PSEL     out  [SLAVES]                one-hot slave selects
//  SLV_PRDATA   in   [SLAVES][PDATA_SIZE]    slave read data
//  SLV_PREADY   in   [SLAVES]                slave ready
//  SLV_PSLVERR  in   [SLAVES]                slave error
// BEHAVIOUR
//  hit[s] = (MST_PADDR & slv_mask[s]) == (slv_addr[s] & slv_mask[s]).
//  Winner is the lowest s with hit; no hit means the transfer is unmapped.
//  FSM states (apb_mux_pkg::state_t) are IDLE, ACCESS, ERR. Reset gives IDLE, sel_idx=0, cnt=0.
//  All outputs are 0 in reset and in IDLE, except the setup-phase SLV_PSEL below.
//  IDLE:
//   - SLV_PSEL[win] = MST_PSEL & ~MST_PENABLE & hit, combinational. Slave sees its setup phase in the same cycle.
//   - On MST_PSEL & ~MST_PENABLE: latch sel_idx=win. Next state is ACCESS on hit, else ERR.
//   - MST_PENABLE=1 while in IDLE (protocol violation) is ignored: no select, no PREADY.
//  ACCESS:
//   - SLV_PSEL[sel_idx]=1 and all others 0.
//   - MST_PRDATA/MST_PREADY/MST_PSLVERR = SLV_*[sel_idx], gated by MST_PENABLE.
//   - On MST_PENABLE & SLV_PREADY[sel_idx]: transfer completes, go to IDLE. A back-to-back setup is decoded in the following IDLE cycle.
//  ERR:
//   - No SLV_PSEL asserted.
//   - When MST_PENABLE: MST_PREADY=1, MST_PSLVERR=1, MST_PRDATA=0 for exactly one cycle, then go to IDLE.
//  MST_PSEL low in ACCESS or ERR (master abort) forces IDLE next cycle, with all SLV_PSEL low from that cycle.
//  PRESET asserted mid-transfer takes effect on the next edge: IDLE, selects low. The slave sees PSEL drop.
//  Latency: zero added cycles. A zero-wait slave completes in 2 cycles, same as direct APB.
// CONFIGURATION
//  APB_MUX_TIMEOUT_EN defined:
//   - cnt ($clog2(TIMEOUT+1) bits) clears on entering ACCESS.
//   - cnt increments each ACCESS cycle with MST_PENABLE & ~SLV_PREADY[sel_idx].
//   - When cnt==TIMEOUT and the slave is still not ready: MST_PREADY=1, MST_PSLVERR=1, MST_PRDATA=0 for that cycle; SLV_PSEL drops next cycle; go to IDLE.
//   - SLV_PREADY in the timeout cycle wins: normal completion, no error.
//  APB_MUX_TIMEOUT_EN undefined: no counter, TIMEOUT unused, ACCESS waits indefinitely.
// STRUCTURE
//  apb_mux_pkg: state_t enum {IDLE, ACCESS, ERR}; function sel_width(SLAVES) returning max(1, $clog2(SLAVES)).
//  Sub-module apb_mux_dec: combinational address compare and priority encoder. Outputs win index and hit flag.
//  Top level: FSM, sel_idx register, optional cnt, response steering.
// TESTING
//  1 slv0 addr 0x10 mask 0xF0; read 0x13, slave ready at once:
//    SLV_PSEL[0] high 2 cycles; MST_PRDATA=SLV_PRDATA[0]; MST_PREADY in cycle 2.
//  2 slv2 and slv5 both match 0x40 (mask 0xC0): only SLV_PSEL[2] asserts; SLV_PREADY[5] is ignored.
//  3 address 0xFF with no match: no SLV_PSEL; MST_PREADY=1, MST_PSLVERR=1, MST_PRDATA=0 in the access cycle.
//  4 APB_MUX_TIMEOUT_EN, TIMEOUT=4, slave never ready:
//    MST_PREADY and MST_PSLVERR on the 5th access cycle; SLV_PSEL low next cycle; FSM IDLE.
//  5 PRESET during a wait state of slave 1: next cycle all outputs 0, FSM IDLE.
//    A new transfer to slave 3 then completes normally.
//  6 back-to-back transfers slv1 then slv4, no idle between:
//    select switches in the setup cycle of the 2nd transfer; both complete correctly.

Source files
------------

// File: rtl/apb_mux_pkg.sv
// Shared types and helpers for the APB slave multiplexer.
package apb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2
    } state_t;

    // Width of a slave index; a single slave still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_mux_dec.sv
// Address decoder: per-slave masked compare plus lowest-index priority encoder.
module apb_mux_dec
    import apb_mux_pkg::*;
#(
    parameter int PADDR_SIZE = 8,
    parameter int SLAVES     = 8,
    parameter int SW         = sel_width(SLAVES)
) (
    input  logic [PADDR_SIZE-1:0]             paddr,
    input  logic [SLAVES-1:0][PADDR_SIZE-1:0] slv_addr,
    input  logic [SLAVES-1:0][PADDR_SIZE-1:0] slv_mask,
    output logic [SW-1:0]                     win,
    output logic                              hit
);

    logic [SLAVES-1:0] hits;

    genvar s;
    generate
        for (s = 0; s < SLAVES; s++) begin : g_cmp
            assign hits[s] = (paddr & slv_mask[s]) == (slv_addr[s] & slv_mask[s]);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last written.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit = 1'b1;
                win = SW'(i);
            end
        end
    end

endmodule

// File: rtl/apb_mux_tmo.sv
// APB4 slave multiplexer with latched slave select, unmapped-address error
// response and an optional access-phase watchdog (enable with APB_MUX_TIMEOUT_EN).
module apb_mux_tmo
    import apb_mux_pkg::*;
#(
    parameter int PADDR_SIZE = 8,
    parameter int PDATA_SIZE = 32,
    parameter int SLAVES     = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                              PCLK,
    input  logic                              PRESET,
    input  logic                              MST_PSEL,
    input  logic                              MST_PENABLE,
    input  logic [PADDR_SIZE-1:0]             MST_PADDR,
    output logic [PDATA_SIZE-1:0]             MST_PRDATA,
    output logic                              MST_PREADY,
    output logic                              MST_PSLVERR,
    input  logic [SLAVES-1:0][PADDR_SIZE-1:0] slv_addr,
    input  logic [SLAVES-1:0][PADDR_SIZE-1:0] slv_mask,
    output logic [SLAVES-1:0]                 SLV_PSEL,
    input  logic [SLAVES-1:0][PDATA_SIZE-1:0] SLV_PRDATA,
    input  logic [SLAVES-1:0]                 SLV_PREADY,
    input  logic [SLAVES-1:0]                 SLV_PSLVERR
);

    localparam int SW = sel_width(SLAVES);

    state_t          state;
    logic [SW-1:0]   sel_idx;
    logic [SW-1:0]   win;
    logic            hit;
    logic            setup;
    logic            tmo_hit;

    apb_mux_dec #(
        .PADDR_SIZE (PADDR_SIZE),
        .SLAVES     (SLAVES),
        .SW         (SW)
    ) u_dec (
        .paddr    (MST_PADDR),
        .slv_addr (slv_addr),
        .slv_mask (slv_mask),
        .win      (win),
        .hit      (hit)
    );

    assign setup = MST_PSEL & ~MST_PENABLE;

`ifdef APB_MUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // Watchdog fires only while the latched slave still holds off ready.
    assign tmo_hit = (cnt == CW'(TIMEOUT)) & ~SLV_PREADY[sel_idx];
`else
    assign tmo_hit = 1'b0;
`endif

    // FSM: latch the winner at setup, leave ACCESS on completion, abort or timeout.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            sel_idx <= '0;
`ifdef APB_MUX_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        sel_idx <= win;
                        state   <= hit ? ACCESS : ERR;
`ifdef APB_MUX_TIMEOUT_EN
                        cnt     <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (!MST_PSEL) begin
                        state <= IDLE;
                    end else if (MST_PENABLE) begin
                        if (SLV_PREADY[sel_idx] || tmo_hit) begin
                            state <= IDLE;
                        end
`ifdef APB_MUX_TIMEOUT_EN
                        else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end
                ERR: begin
                    if (!MST_PSEL || MST_PENABLE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response steering: zero added latency, so selects and returns are combinational.
    always_comb begin
        SLV_PSEL    = '0;
        MST_PRDATA  = '0;
        MST_PREADY  = 1'b0;
        MST_PSLVERR = 1'b0;
        case (state)
            IDLE: begin
                if (setup && hit) SLV_PSEL[win] = 1'b1;
            end
            ACCESS: begin
                // A master abort drops the slave select in the same cycle.
                if (MST_PSEL) begin
                    SLV_PSEL[sel_idx] = 1'b1;
                    if (MST_PENABLE) begin
                        if (tmo_hit) begin
                            MST_PREADY  = 1'b1;
                            MST_PSLVERR = 1'b1;
                        end else begin
                            MST_PRDATA  = SLV_PRDATA[sel_idx];
                            MST_PREADY  = SLV_PREADY[sel_idx];
                            MST_PSLVERR = SLV_PSLVERR[sel_idx];
                        end
                    end
                end
            end
            ERR: begin
                if (MST_PSEL && MST_PENABLE) begin
                    MST_PREADY  = 1'b1;
                    MST_PSLVERR = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
